renkon_linebuf_stride: RTL and testbench
========================================

Name: renkon_linebuf_stride

Overview:
Next-generation line buffer for the renkon conv datapath. Consumes a raster-scanned single-channel image one pixel per accepted beat and emits fil_size x fil_size sliding windows to the PE array. Adds over the first-generation buffer: runtime filter size up to MAXFIL, runtime stride (1 or 2), an input valid so upstream DMA may stall, and config validation. Sits between the input-feature DMA and renkon_core.

Parameters:
DWIDTH, 16, pixel width (signed)
LWIDTH, 10, width of size/count registers
MAXFIL, 5, largest supported filter edge
MAXIMG, 32, largest supported image edge (line memory depth)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
buf_req  in  1  start pulse; sampled only in S_IDLE
buf_ack  out  1  high when idle/finished, low while a frame is in progress
img_size  in  LWIDTH  image edge N, latched on accepted buf_req
fil_size  in  LWIDTH  filter edge F, latched on accepted buf_req
stride  in  2  1 or 2, latched on accepted buf_req
in_valid  in  1  buf_input carries a pixel this cycle
buf_input  in  DWIDTH signed  pixel, raster order, row-major
buf_valid  out  1  one-cycle pulse: buf_output holds a new window
buf_output  out  MAXFIL**2 x DWIDTH signed  window, index MAXFIL*di+dj, (0,0) = top-left

Behaviour:
- Reset: state S_IDLE, buf_ack=1, buf_valid=0, all buf_output=0, row/col counters 0, line-memory select 0. rst mid-frame aborts immediately; line memory contents are don't-care afterwards.
- States: S_IDLE -> (buf_req) S_CHECK -> S_RUN (config valid) or S_DONE (invalid); S_RUN -> S_DONE after last window emitted; S_DONE -> S_IDLE next cycle.
- buf_ack falls the cycle after buf_req is accepted, rises on entry to S_IDLE. buf_req outside S_IDLE is ignored.
- Valid config: 1<=F<=MAXFIL, F<=N<=MAXIMG, stride in {1,2}. Otherwise no windows, no pixels consumed, back to S_IDLE in 3 cycles.
- Pixels consumed only in S_RUN with in_valid=1; counters (row r, col c) advance only on consumed beats; in_valid in other states is ignored.
- Window emission: consuming pixel (r,c) with r>=F-1, c>=F-1, (r-F+1)%stride==0, (c-F+1)%stride==0 produces the window with top-left (r-F+1, c-F+1). buf_valid pulses exactly 2 cycles after that beat, regardless of later stalls.
- Window count = ((N-F)/stride+1)^2 (integer division); raster order.
- Taps with di>=F or dj>=F are driven 0. buf_output holds its value between pulses.
- Line storage: MAXFIL-1 line memories of MAXIMG words, rotated per row (select wraps at F-1, not MAXFIL-1); read-before-write at address c. Plus an MAXFIL x MAXFIL shift-register window; column shift only on consumed beats.
- Frame ends when pixel (N-1,N-1) is consumed; S_DONE entered after its window pulse (if any) has been issued.
- Stride arithmetic uses phase counters reset at r=F-1/c=F-1, no modulo hardware.

Decomposition:
- renkon.svh / package: DWIDTH, LWIDTH, MAXFIL, MAXIMG defaults, state enum (S_IDLE, S_CHECK, S_RUN, S_DONE), window tap index helper.
- Sub-module renkon_linebuf_mem: single-port synchronous RAM, read-before-write, MAXIMG x DWIDTH; instantiated MAXFIL-1 times.

Test Plan:
- N=32, F=3, stride=1, pixel=r*32+c, in_valid always high -> 900 pulses; block 0 = {0,1,2;32,33,34;64,65,66}; block 899 top-left 957; buf_ack high 2 cycles after last pulse; unused taps 0.
- N=32, F=3, stride=2 -> 225 pulses; block 1 top-left value 2; block 15 top-left value 64.
- N=32, F=5, stride=1 -> 784 pulses; block 0 row 4 = {128..132}; all 25 taps populated.
- Same as case 1 with random in_valid (~50% duty) -> identical window sequence, each pulse 2 cycles after its bottom-right beat.
- fil_size=6 or img_size=2,F=3 or stride=3 -> zero pulses, buf_ack low for exactly 3 cycles.
- rst asserted at window 100 of case 1, then new req with N=8,F=3 -> 36 correct windows, none stale.

Source files
------------

// File: rtl/renkon_linebuf_stride_pkg.sv
// rtl/renkon_linebuf_stride_pkg.sv - shared constants, FSM states and tap indexing for the stride line buffer
// Contents:
//   DEF_*    default widths and limits for the line buffer parameters
//   state_t  frame sequencer states
//   tap_idx  flat index of window tap (di, dj) in the output vector
package renkon_linebuf_stride_pkg;

    localparam int DEF_DWIDTH = 16;
    localparam int DEF_LWIDTH = 10;
    localparam int DEF_MAXFIL = 5;
    localparam int DEF_MAXIMG = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Row-major tap numbering: (0,0) is the top-left pixel of the window.
    function automatic int tap_idx(input int maxfil, input int di, input int dj);
        return maxfil * di + dj;
    endfunction

endpackage

// File: rtl/renkon_linebuf_mem.sv
// rtl/renkon_linebuf_mem.sv - single-port synchronous line memory, read-before-write
// Ports:
//   clk    clock
//   en     access enable; rdata updates only on enabled cycles
//   we     write enable (qualified by en)
//   addr   word address (pixel column)
//   wdata  word to store
//   rdata  word previously held at addr, registered
module renkon_linebuf_mem #(
    parameter int DWIDTH = 16,
    parameter int DEPTH  = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic                     we,
    input  logic [AW-1:0]            addr,
    input  logic signed [DWIDTH-1:0] wdata,
    output logic signed [DWIDTH-1:0] rdata
);

    logic signed [DWIDTH-1:0] mem [DEPTH];

    // Old contents come out while the new pixel of the same column goes in,
    // so one access per beat both retires and refills a line slot.
    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[addr];
            if (we) begin
                mem[addr] <= wdata;
            end
        end
    end

endmodule

// File: rtl/renkon_linebuf_stride.sv
// rtl/renkon_linebuf_stride.sv - runtime F x F sliding-window line buffer with stride 1/2
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   buf_req / buf_ack    frame start pulse (taken in S_IDLE) / idle indicator
//   img_size, fil_size   image edge N and filter edge F, latched on accepted buf_req
//   stride               window step (1 or 2), latched on accepted buf_req
//   in_valid, buf_input  raster-order pixel stream; consumed only while running
//   buf_valid            one-cycle pulse, 2 cycles after the window's bottom-right beat
//   buf_output           MAXFIL*MAXFIL taps, index MAXFIL*di+dj, unused taps 0
module renkon_linebuf_stride
    import renkon_linebuf_stride_pkg::*;
#(
    parameter int DWIDTH = DEF_DWIDTH,
    parameter int LWIDTH = DEF_LWIDTH,
    parameter int MAXFIL = DEF_MAXFIL,
    parameter int MAXIMG = DEF_MAXIMG
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     buf_req,
    output logic                     buf_ack,
    input  logic [LWIDTH-1:0]        img_size,
    input  logic [LWIDTH-1:0]        fil_size,
    input  logic [1:0]               stride,
    input  logic                     in_valid,
    input  logic signed [DWIDTH-1:0] buf_input,
    output logic                     buf_valid,
    output logic signed [DWIDTH-1:0] buf_output [MAXFIL*MAXFIL]
);

    localparam int AW   = $clog2(MAXIMG);
    localparam int NMEM = MAXFIL - 1;
    localparam int SELW = (NMEM > 1) ? $clog2(NMEM) : 1;

    state_t state, state_nx;

    logic [LWIDTH-1:0] n_q, f_q, fm1;
    logic [1:0]        stride_q;
    logic [LWIDTH-1:0] row, col;
    logic              ph_r, ph_c;
    logic [SELW-1:0]   sel;
    logic              draining;

    logic cfg_ok, consume, last_col, last_row, last_beat, emit_now, stride2;

    logic                     s1_valid, s1_emit, s1_last;
    logic signed [DWIDTH-1:0] s1_pix;
    logic [SELW-1:0]          s1_sel;

    logic signed [DWIDTH-1:0] rd     [NMEM];
    logic [LWIDTH-1:0]        rd_idx [MAXFIL];
    logic signed [DWIDTH-1:0] column [MAXFIL];
    logic signed [DWIDTH-1:0] win    [MAXFIL][MAXFIL];
    logic signed [DWIDTH-1:0] win_nx [MAXFIL][MAXFIL];

    assign fm1      = f_q - LWIDTH'(1);
    assign stride2  = (stride_q == 2'd2);
    assign cfg_ok   = (f_q >= LWIDTH'(1)) && (f_q <= LWIDTH'(MAXFIL)) &&
                      (n_q >= f_q) && (n_q <= LWIDTH'(MAXIMG)) &&
                      ((stride_q == 2'd1) || (stride_q == 2'd2));
    // Once the last pixel is in, further beats are refused until the frame closes.
    assign consume   = (state == S_RUN) && in_valid && !draining;
    assign last_col  = (col == n_q - LWIDTH'(1));
    assign last_row  = (row == n_q - LWIDTH'(1));
    assign last_beat = consume && last_col && last_row;
    // Phase bits are 0 on every stride-th row/column counted from F-1.
    assign emit_now  = consume && (row >= fm1) && (col >= fm1) && !ph_r && !ph_c;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (buf_req) state_nx = S_CHECK;
            S_CHECK: state_nx = cfg_ok ? S_RUN : S_DONE;
            S_RUN:   if (s1_valid && s1_last) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            buf_ack  <= 1'b1;
            n_q      <= '0;
            f_q      <= '0;
            stride_q <= '0;
            row      <= '0;
            col      <= '0;
            ph_r     <= 1'b0;
            ph_c     <= 1'b0;
            sel      <= '0;
            draining <= 1'b0;
        end else begin
            state   <= state_nx;
            // Registered so the ack stays low through the first idle cycle.
            buf_ack <= (state == S_IDLE) && !buf_req;
            if (state == S_IDLE && buf_req) begin
                n_q      <= img_size;
                f_q      <= fil_size;
                stride_q <= stride;
                row      <= '0;
                col      <= '0;
                ph_r     <= 1'b0;
                ph_c     <= 1'b0;
                sel      <= '0;
                draining <= 1'b0;
            end else if (consume) begin
                if (last_beat) begin
                    draining <= 1'b1;
                end
                if (last_col) begin
                    col  <= '0;
                    ph_c <= 1'b0;
                    row  <= row + LWIDTH'(1);
                    ph_r <= (row >= fm1 && stride2) ? ~ph_r : 1'b0;
                    // Rotation spans only the F-1 lines the current filter needs.
                    if (LWIDTH'(sel) + LWIDTH'(1) >= fm1) begin
                        sel <= '0;
                    end else begin
                        sel <= sel + 1'b1;
                    end
                end else begin
                    col  <= col + LWIDTH'(1);
                    ph_c <= (col >= fm1 && stride2) ? ~ph_c : 1'b0;
                end
            end
        end
    end

    // Memory sel holds the oldest buffered row; it is overwritten by the current row.
    for (genvar k = 0; k < NMEM; k++) begin : g_line
        renkon_linebuf_mem #(
            .DWIDTH (DWIDTH),
            .DEPTH  (MAXIMG)
        ) u_mem (
            .clk   (clk),
            .en    (consume),
            .we    (consume && (sel == SELW'(k))),
            .addr  (col[AW-1:0]),
            .wdata (buf_input),
            .rdata (rd[k])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_emit  <= 1'b0;
            s1_last  <= 1'b0;
            s1_pix   <= '0;
            s1_sel   <= '0;
        end else begin
            s1_valid <= consume;
            s1_emit  <= emit_now;
            s1_last  <= last_beat;
            s1_pix   <= buf_input;
            s1_sel   <= sel;
        end
    end

    // Window column, top to bottom: memories sel, sel+1, ... (mod F-1), then the live pixel.
    always_comb begin
        for (int di = 0; di < MAXFIL; di++) begin
            rd_idx[di] = LWIDTH'(s1_sel) + LWIDTH'(di);
            if (rd_idx[di] >= fm1) begin
                rd_idx[di] = rd_idx[di] - fm1;
            end
            column[di] = '0;
            if (LWIDTH'(di) < fm1) begin
                column[di] = rd[rd_idx[di][SELW-1:0]];
            end else if (LWIDTH'(di) == fm1) begin
                column[di] = s1_pix;
            end
        end
    end

    // Shift left by one column; the new column enters at dj = F-1, taps beyond F clear.
    always_comb begin
        for (int di = 0; di < MAXFIL; di++) begin
            for (int dj = 0; dj < MAXFIL; dj++) begin
                win_nx[di][dj] = '0;
            end
            for (int dj = 0; dj < MAXFIL - 1; dj++) begin
                if (LWIDTH'(dj) < fm1) begin
                    win_nx[di][dj] = win[di][dj+1];
                end
            end
            for (int dj = 0; dj < MAXFIL; dj++) begin
                if (LWIDTH'(dj) == fm1) begin
                    win_nx[di][dj] = column[di];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid <= 1'b0;
            for (int di = 0; di < MAXFIL; di++) begin
                for (int dj = 0; dj < MAXFIL; dj++) begin
                    win[di][dj] <= '0;
                    buf_output[tap_idx(MAXFIL, di, dj)] <= '0;
                end
            end
        end else begin
            buf_valid <= s1_valid && s1_emit;
            if (s1_valid) begin
                for (int di = 0; di < MAXFIL; di++) begin
                    for (int dj = 0; dj < MAXFIL; dj++) begin
                        win[di][dj] <= win_nx[di][dj];
                    end
                end
            end
            if (s1_valid && s1_emit) begin
                for (int di = 0; di < MAXFIL; di++) begin
                    for (int dj = 0; dj < MAXFIL; dj++) begin
                        buf_output[tap_idx(MAXFIL, di, dj)] <= win_nx[di][dj];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_renkon_linebuf_stride.sv
// tb/tb_renkon_linebuf_stride.sv - randomized scoreboard bench for renkon_linebuf_stride
module tb_renkon_linebuf_stride;
    import renkon_linebuf_stride_pkg::*;

    localparam int DW = 16;
    localparam int LW = 10;
    localparam int MF = 5;
    localparam int MI = 32;
    localparam int NT = MF * MF;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 buf_req;
    logic                 buf_ack;
    logic [LW-1:0]        img_size;
    logic [LW-1:0]        fil_size;
    logic [1:0]           stride;
    logic                 in_valid;
    logic signed [DW-1:0] buf_input;
    logic                 buf_valid;
    logic signed [DW-1:0] buf_output [NT];

    renkon_linebuf_stride #(
        .DWIDTH (DW),
        .LWIDTH (LW),
        .MAXFIL (MF),
        .MAXIMG (MI)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .buf_req    (buf_req),
        .buf_ack    (buf_ack),
        .img_size   (img_size),
        .fil_size   (fil_size),
        .stride     (stride),
        .in_valid   (in_valid),
        .buf_input  (buf_input),
        .buf_valid  (buf_valid),
        .buf_output (buf_output)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [NT*DW-1:0] win;
        int               cyc;
    } exp_t;

    exp_t exp_q [$];
    int   n_vec = 0;
    int   n_fail = 0;
    int   pulses = 0;
    int   tl_q [$];
    logic [NT*DW-1:0] first_win;
    logic [NT*DW-1:0] got_w;
    exp_t mon_e;
    logic signed [DW-1:0] img [MI][MI];

    task automatic check(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    function automatic logic [NT*DW-1:0] mkwin(input int top, input int left, input int f);
        logic [NT*DW-1:0] w;
        w = '0;
        for (int di = 0; di < MF; di++)
            for (int dj = 0; dj < MF; dj++)
                if (di < f && dj < f)
                    w[(MF*di+dj)*DW +: DW] = img[top+di][left+dj];
        return w;
    endfunction

    always @(negedge clk) begin
        if (!rst && buf_valid) begin
            for (int k = 0; k < NT; k++) got_w[k*DW +: DW] = buf_output[k];
            pulses++;
            if (pulses == 1) first_win = got_w;
            tl_q.push_back(int'(buf_output[0]));
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_pulse cyc=%0d tap0=%0d want=no_pulse", cyc, buf_output[0]);
            end else begin
                mon_e = exp_q.pop_front();
                n_vec++;
                if (got_w !== mon_e.win) begin
                    n_fail++;
                    for (int k = 0; k < NT; k++)
                        if (got_w[k*DW +: DW] !== mon_e.win[k*DW +: DW]) begin
                            $display("FAIL window pulse=%0d tap=%0d got=%0d want=%0d", pulses, k,
                                     $signed(got_w[k*DW +: DW]), $signed(mon_e.win[k*DW +: DW]));
                            break;
                        end
                end
                check("pulse_latency", cyc, mon_e.cyc);
            end
        end
    end

    task automatic start_req(input int n, input int f, input int s);
        pulses = 0;
        tl_q.delete();
        buf_req  = 1'b1;
        img_size = LW'(n);
        fil_size = LW'(f);
        stride   = 2'(s);
        @(posedge clk); #1;
        buf_req = 1'b0;
        check("ack_falls", int'(buf_ack), 0);
        @(posedge clk); #1;
    endtask

    task automatic run_frame(input int n, input int f, input int s, input int rnd_pix,
                             input int duty, input int abort_at, output int aborted);
        int r, c, last_cyc, ack_cyc, want_cnt;
        exp_t e;
        aborted = 0;
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++)
                img[i][j] = rnd_pix ? DW'($urandom) : DW'(i * n + j);
        start_req(n, f, s);
        r = 0; c = 0; last_cyc = cyc;
        while (r < n) begin
            if (abort_at > 0 && pulses >= abort_at) begin
                aborted = 1;
                break;
            end
            if (int'($urandom_range(0, 99)) < duty) begin
                in_valid  = 1'b1;
                buf_input = img[r][c];
                last_cyc  = cyc;
                if (r >= f-1 && c >= f-1 && (r-f+1) % s == 0 && (c-f+1) % s == 0) begin
                    e.win = mkwin(r-f+1, c-f+1, f);
                    e.cyc = cyc + 2;
                    exp_q.push_back(e);
                end
                c++;
                if (c == n) begin c = 0; r++; end
            end else begin
                in_valid  = 1'b0;
                buf_input = DW'($urandom);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (aborted == 0) begin
            ack_cyc = -1;
            for (int t = 0; t < 50; t++) begin
                if (buf_ack) begin ack_cyc = cyc; break; end
                @(posedge clk); #1;
            end
            check("ack_rise_cycle", ack_cyc, last_cyc + 4);
            want_cnt = ((n - f) / s + 1) * ((n - f) / s + 1);
            check("window_count", pulses, want_cnt);
            check("queue_drained", exp_q.size(), 0);
        end
    endtask

    task automatic bad_frame(input int n, input int f, input int s);
        int low;
        start_req(n, f, s);
        low = 1;
        in_valid = 1'b1;
        for (int t = 0; t < 20 && !buf_ack; t++) begin
            low++;
            buf_input = DW'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("bad_cfg_ack_low", low, 3);
        check("bad_cfg_pulses", pulses, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int ab, nz, n, f, s;
        rst = 1'b1; buf_req = 1'b0; in_valid = 1'b0; buf_input = '0;
        img_size = '0; fil_size = '0; stride = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        nz = 0;
        for (int k = 0; k < NT; k++) if (buf_output[k] != 0) nz++;
        check("reset_out_nonzero", nz, 0);
        check("reset_ack", int'(buf_ack), 1);
        check("reset_valid", int'(buf_valid), 0);

        run_frame(32, 3, 1, 0, 100, 0, ab);
        for (int k = 0; k < NT; k++)
            check("c1_block0_tap", int'($signed(first_win[k*DW +: DW])),
                  ((k / MF) < 3 && (k % MF) < 3) ? 32 * (k / MF) + (k % MF) : 0);
        if (tl_q.size() > 899) check("c1_block899_tl", tl_q[899], 957);
        else check("c1_block899_present", tl_q.size(), 900);

        run_frame(32, 3, 2, 0, 100, 0, ab);
        if (tl_q.size() > 15) begin
            check("c2_block1_tl", tl_q[1], 2);
            check("c2_block15_tl", tl_q[15], 64);
        end else check("c2_blocks_present", tl_q.size(), 225);

        run_frame(32, 5, 1, 0, 100, 0, ab);
        for (int j = 0; j < 5; j++)
            check("c3_block0_row4", int'($signed(first_win[(MF*4+j)*DW +: DW])), 128 + j);

        run_frame(32, 3, 1, 0, 50, 0, ab);

        bad_frame(32, 6, 1);
        bad_frame(2, 3, 1);
        bad_frame(32, 3, 3);

        run_frame(32, 3, 1, 0, 100, 100, ab);
        check("abort_taken", ab, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        check("abort_valid_low", int'(buf_valid), 0);
        check("abort_ack_high", int'(buf_ack), 1);
        run_frame(8, 3, 1, 0, 100, 0, ab);

        for (int i = 0; i < 6; i++) begin
            f = int'($urandom_range(1, 5));
            n = int'($urandom_range(f, 12));
            s = int'($urandom_range(1, 2));
            run_frame(n, f, s, 1, 70, 0, ab);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
